// File: rtl/fl_pkg.sv
// rtl/fl_pkg.sv - shared types and sizing for the physical-register free-list controller
//
// Purpose: default register-file sizing, preg index type, controller state
// encoding and free-count width shared by freelist_ctrl and its arbiter.
// Ports: none (package).
package fl_pkg;

  localparam int FL_NUM_PHYS = 64;
  localparam int FL_NUM_ARCH = 32;
  localparam int LOG_PHYS    = $clog2(FL_NUM_PHYS);
  localparam int COUNT_W     = LOG_PHYS + 1;

  typedef logic [LOG_PHYS-1:0] preg_t;
  typedef logic [COUNT_W-1:0]  count_t;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    RUN     = 2'd1,
    RECOVER = 2'd2
  } fl_state_t;

endpackage

// File: rtl/free_src_arb.sv
// rtl/free_src_arb.sv - fixed-priority walker/squash/commit enqueue mux
//
// Purpose: picks one of three free sources for the single free-list enqueue
// port. Priority: walker > squash > commit.
// Ports:
//   walker_req_i / walker_data_i  : initialisation walker request and preg
//   squash_en_i                   : squash source may be served this cycle
//   squash_free_i / squash_preg_i : squash free request and preg
//   commit_en_i                   : commit source may be served this cycle
//   commit_free_i / commit_preg_i : commit free request and preg
//   squash_rdy_o / commit_rdy_o   : source would be accepted if presenting
//   enq_o / enq_data_o            : selected enqueue strobe and data
module free_src_arb #(
  parameter int W = 6
) (
  input  logic         walker_req_i,
  input  logic [W-1:0] walker_data_i,
  input  logic         squash_en_i,
  input  logic         squash_free_i,
  input  logic [W-1:0] squash_preg_i,
  input  logic         commit_en_i,
  input  logic         commit_free_i,
  input  logic [W-1:0] commit_preg_i,
  output logic         squash_rdy_o,
  output logic         commit_rdy_o,
  output logic         enq_o,
  output logic [W-1:0] enq_data_o
);

  logic squash_req;
  logic commit_req;

  assign squash_req   = squash_en_i & squash_free_i;
  assign commit_req   = commit_en_i & commit_free_i;

  assign squash_rdy_o = squash_en_i & ~walker_req_i;
  assign commit_rdy_o = commit_en_i & ~walker_req_i & ~squash_req;

  always_comb begin
    enq_o      = 1'b0;
    enq_data_o = '0;
    if (walker_req_i) begin
      enq_o      = 1'b1;
      enq_data_o = walker_data_i;
    end else if (squash_req) begin
      enq_o      = 1'b1;
      enq_data_o = squash_preg_i;
    end else if (commit_req) begin
      enq_o      = 1'b1;
      enq_data_o = commit_preg_i;
    end
  end

endmodule

// File: rtl/freelist_ctrl.sv
// rtl/freelist_ctrl.sv - rename-stage physical-register free-list controller
//
// Purpose: fills the free list with non-architectural pregs after reset,
// serves one allocation port, arbitrates commit/squash frees onto the free
// list enqueue port, tracks the free count and flags free-list failures.
// Ports:
//   CLK, RESET                          : clock, synchronous active-high reset
//   Alloc_Req/Ready/Valid/Preg          : rename allocation port (1-cycle latency)
//   Commit_Free/Preg/Ready              : commit free source
//   Squash_Start/Free/Preg/Ready/Done   : squash recovery and its free source
//   FL_Enqueue/EnqData/Dequeue          : free-list strobes
//   FL_EnqueueResult/DequeueResult/DeqData : free-list registered responses
//   Free_Count_OUT, Busy_OUT, Error_OUT : status
module freelist_ctrl
  import fl_pkg::*;
#(
  parameter  int NUM_PHYS_REGS = FL_NUM_PHYS,
  parameter  int NUM_ARCH_REGS = FL_NUM_ARCH,
  localparam int LP            = $clog2(NUM_PHYS_REGS),
  localparam int CW            = LP + 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          Alloc_Req_IN,
  output logic          Alloc_Ready_OUT,
  output logic          Alloc_Valid_OUT,
  output logic [LP-1:0] Alloc_Preg_OUT,
  input  logic          Commit_Free_IN,
  input  logic [LP-1:0] Commit_Preg_IN,
  output logic          Commit_Ready_OUT,
  input  logic          Squash_Start_IN,
  input  logic          Squash_Free_IN,
  input  logic [LP-1:0] Squash_Preg_IN,
  output logic          Squash_Ready_OUT,
  input  logic          Squash_Done_IN,
  output logic          FL_Enqueue_OUT,
  output logic [LP-1:0] FL_EnqData_OUT,
  output logic          FL_Dequeue_OUT,
  input  logic          FL_EnqueueResult_IN,
  input  logic          FL_DequeueResult_IN,
  input  logic [LP-1:0] FL_DeqData_IN,
  output logic [CW-1:0] Free_Count_OUT,
  output logic          Busy_OUT,
  output logic          Error_OUT
);

  fl_state_t     state_q, state_d;
  logic [LP-1:0] walker_q, walker_d;
  logic [CW-1:0] count_q, count_d;
  logic          error_q, error_d;
  logic          enq_pend_q, deq_pend_q;

  logic          walker_req, squash_en, commit_en;
  logic          arb_sq_rdy, arb_cm_rdy, arb_enq;
  logic [LP-1:0] arb_data;
  logic          full, enq_fire, enq_overflow;
  logic          alloc_ready, deq_fire;
  logic          enq_fail, deq_fail;

  // Source enables are all dropped during RESET so no strobe or ready leaks out.
  assign walker_req = (state_q == INIT) & ~RESET;
  assign squash_en  = (state_q != INIT) & ~RESET;
  assign commit_en  = (state_q == RUN)  & ~RESET;

  free_src_arb #(.W(LP)) u_arb (
    .walker_req_i  (walker_req),
    .walker_data_i (walker_q),
    .squash_en_i   (squash_en),
    .squash_free_i (Squash_Free_IN),
    .squash_preg_i (Squash_Preg_IN),
    .commit_en_i   (commit_en),
    .commit_free_i (Commit_Free_IN),
    .commit_preg_i (Commit_Preg_IN),
    .squash_rdy_o  (arb_sq_rdy),
    .commit_rdy_o  (arb_cm_rdy),
    .enq_o         (arb_enq),
    .enq_data_o    (arb_data)
  );

  // A full list swallows the enqueue and raises the error instead.
  assign full         = (count_q == CW'(NUM_PHYS_REGS));
  assign enq_fire     = arb_enq & ~full;
  assign enq_overflow = arb_enq & full;

  // Registered count only: a free arriving this cycle cannot be allocated this cycle.
  assign alloc_ready  = (state_q == RUN) & (count_q != '0) & ~RESET;
  assign deq_fire     = Alloc_Req_IN & alloc_ready;

  assign enq_fail     = enq_pend_q & ~FL_EnqueueResult_IN;
  assign deq_fail     = deq_pend_q & ~FL_DequeueResult_IN;

  always_comb begin
    state_d  = state_q;
    walker_d = walker_q;
    unique case (state_q)
      INIT: begin
        if (enq_fire) begin
          if (walker_q == LP'(NUM_PHYS_REGS - 1)) state_d = RUN;
          else                                    walker_d = walker_q + 1'b1;
        end
      end
      RUN:     if (Squash_Start_IN) state_d = RECOVER;
      RECOVER: if (Squash_Done_IN)  state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (enq_fire && !deq_fire)      count_d = count_q + 1'b1;
    else if (deq_fire && !enq_fire) count_d = count_q - 1'b1;
  end

  assign error_d = error_q | enq_overflow | enq_fail | deq_fail;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= INIT;
      walker_q   <= LP'(NUM_ARCH_REGS);
      count_q    <= '0;
      error_q    <= 1'b0;
      enq_pend_q <= 1'b0;
      deq_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      walker_q   <= walker_d;
      count_q    <= count_d;
      error_q    <= error_d;
      enq_pend_q <= enq_fire;
      deq_pend_q <= deq_fire;
    end
  end

  assign Alloc_Ready_OUT  = alloc_ready;
  assign FL_Dequeue_OUT   = deq_fire;
  // Delivery rides directly on the free list's registered response.
  assign Alloc_Valid_OUT  = deq_pend_q & FL_DequeueResult_IN & ~RESET;
  assign Alloc_Preg_OUT   = FL_DeqData_IN;
  assign Commit_Ready_OUT = arb_cm_rdy;
  // In RUN the squash port is only ready when it actually presents a free.
  assign Squash_Ready_OUT = arb_sq_rdy & ((state_q == RECOVER) | Squash_Free_IN);
  assign FL_Enqueue_OUT   = enq_fire;
  assign FL_EnqData_OUT   = arb_data;
  assign Free_Count_OUT   = count_q;
  assign Busy_OUT         = (state_q != RUN);
  assign Error_OUT        = error_q;

endmodule

// File: tb/tb_freelist_ctrl.sv
// tb/tb_freelist_ctrl.sv - directed self-checking bench for freelist_ctrl
module tb_freelist_ctrl;

  logic       clk;
  logic       reset;
  logic       alloc_req;
  logic       alloc_ready, alloc_valid;
  logic [5:0] alloc_preg;
  logic       commit_free, commit_ready;
  logic [5:0] commit_preg;
  logic       squash_start, squash_free, squash_ready, squash_done;
  logic [5:0] squash_preg;
  logic       fl_enq, fl_deq;
  logic [5:0] fl_enq_data;
  logic       fl_enq_res, fl_deq_res;
  logic [5:0] fl_deq_data;
  logic [6:0] free_count;
  logic       busy, error;

  logic       force_deq_fail;
  logic [5:0] fl_q[$];

  int n_checks = 0;
  int n_errors = 0;

  freelist_ctrl dut (
    .CLK                 (clk),
    .RESET               (reset),
    .Alloc_Req_IN        (alloc_req),
    .Alloc_Ready_OUT     (alloc_ready),
    .Alloc_Valid_OUT     (alloc_valid),
    .Alloc_Preg_OUT      (alloc_preg),
    .Commit_Free_IN      (commit_free),
    .Commit_Preg_IN      (commit_preg),
    .Commit_Ready_OUT    (commit_ready),
    .Squash_Start_IN     (squash_start),
    .Squash_Free_IN      (squash_free),
    .Squash_Preg_IN      (squash_preg),
    .Squash_Ready_OUT    (squash_ready),
    .Squash_Done_IN      (squash_done),
    .FL_Enqueue_OUT      (fl_enq),
    .FL_EnqData_OUT      (fl_enq_data),
    .FL_Dequeue_OUT      (fl_deq),
    .FL_EnqueueResult_IN (fl_enq_res),
    .FL_DequeueResult_IN (fl_deq_res),
    .FL_DeqData_IN       (fl_deq_data),
    .Free_Count_OUT      (free_count),
    .Busy_OUT            (busy),
    .Error_OUT           (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural free list: FIFO with registered results one cycle after a strobe.
  always @(posedge clk) begin
    if (reset) begin
      fl_q.delete();
      fl_enq_res  <= 1'b0;
      fl_deq_res  <= 1'b0;
      fl_deq_data <= '0;
    end else begin
      fl_enq_res <= fl_enq;
      fl_deq_res <= 1'b0;
      if (fl_deq && !force_deq_fail && fl_q.size() > 0) begin
        fl_deq_res  <= 1'b1;
        fl_deq_data <= fl_q.pop_front();
      end
      if (fl_enq) fl_q.push_back(fl_enq_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; alloc_req = 1'b0; force_deq_fail = 1'b0;
    commit_free = 1'b0; commit_preg = '0;
    squash_start = 1'b0; squash_free = 1'b0; squash_preg = '0; squash_done = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_count", 32'(free_count), 0);
    check("rst_error", 32'(error), 0);
    check("rst_busy", 32'(busy), 1);
    check("rst_enq", 32'(fl_enq), 0);
    check("rst_valid", 32'(alloc_valid), 0);
    check("rst_aready", 32'(alloc_ready), 0);

    // INIT walk with allocation, commit and squash start all presented and ignored
    @(negedge clk);
    reset = 1'b0; alloc_req = 1'b1; commit_free = 1'b1; commit_preg = 6'd5; squash_start = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check("init_enq", 32'(fl_enq), 1);
      check("init_data", 32'(fl_enq_data), 32 + i);
      check("init_aready", 32'(alloc_ready), 0);
      check("init_cready", 32'(commit_ready), 0);
      check("init_busy", 32'(busy), 1);
      if (i == 31) begin
        alloc_req = 1'b0; commit_free = 1'b0; squash_start = 1'b0;
      end
    end
    @(negedge clk); #1;
    check("run_busy", 32'(busy), 0);
    check("run_count", 32'(free_count), 32);
    check("run_enq", 32'(fl_enq), 0);

    // Drain all 32 pregs with Alloc_Req held 34 cycles
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      alloc_req = 1'b1;
      #1;
      check("drain_ready", 32'(alloc_ready), (k < 32) ? 1 : 0);
      check("drain_count", 32'(free_count), (k < 32) ? 32 - k : 0);
      if (k >= 1 && k <= 32) begin
        check("drain_valid", 32'(alloc_valid), 1);
        check("drain_preg", 32'(alloc_preg), 31 + k);
      end else begin
        check("drain_novalid", 32'(alloc_valid), 0);
      end
    end
    @(negedge clk);
    alloc_req = 1'b0;
    #1;
    check("empty_count", 32'(free_count), 0);
    check("empty_error", 32'(error), 0);

    // Commit free at count 0: allocation refused this cycle, served next
    @(negedge clk);
    commit_free = 1'b1; commit_preg = 6'd40; alloc_req = 1'b1;
    #1;
    check("cm_ready", 32'(commit_ready), 1);
    check("cm_aready0", 32'(alloc_ready), 0);
    check("cm_enq", 32'(fl_enq), 1);
    check("cm_data", 32'(fl_enq_data), 40);
    @(negedge clk);
    commit_free = 1'b0;
    #1;
    check("cm_count1", 32'(free_count), 1);
    check("cm_aready1", 32'(alloc_ready), 1);
    check("cm_deq", 32'(fl_deq), 1);
    @(negedge clk);
    alloc_req = 1'b0;
    #1;
    check("cm_valid", 32'(alloc_valid), 1);
    check("cm_preg", 32'(alloc_preg), 40);
    check("cm_count0", 32'(free_count), 0);

    // Squash recovery with a commit free held throughout
    @(negedge clk);
    squash_start = 1'b1;
    #1;
    check("sq_busy0", 32'(busy), 0);
    @(negedge clk);
    squash_start = 1'b0; squash_free = 1'b1; squash_preg = 6'd50;
    commit_free = 1'b1; commit_preg = 6'd45; alloc_req = 1'b1;
    #1;
    check("sq_busy1", 32'(busy), 1);
    check("sq_aready", 32'(alloc_ready), 0);
    check("sq_cready", 32'(commit_ready), 0);
    check("sq_sready", 32'(squash_ready), 1);
    check("sq_enq50", 32'(fl_enq_data), 50);
    @(negedge clk);
    alloc_req = 1'b0; squash_preg = 6'd51; squash_done = 1'b1;
    #1;
    check("sq_enq51", 32'(fl_enq_data), 51);
    check("sq_cready2", 32'(commit_ready), 0);
    check("sq_count1", 32'(free_count), 1);
    @(negedge clk);
    squash_free = 1'b0; squash_done = 1'b0;
    #1;
    check("sq_busy2", 32'(busy), 0);
    check("sq_cready3", 32'(commit_ready), 1);
    check("sq_sready0", 32'(squash_ready), 0);
    check("sq_enq45", 32'(fl_enq_data), 45);
    check("sq_count2", 32'(free_count), 2);
    @(negedge clk);
    commit_free = 1'b0;
    #1;
    check("sq_count3", 32'(free_count), 3);
    check("sq_noenq", 32'(fl_enq), 0);

    // Failed dequeue: no delivery, sticky error
    @(negedge clk);
    alloc_req = 1'b1; force_deq_fail = 1'b1;
    #1;
    check("df_deq", 32'(fl_deq), 1);
    check("df_err0", 32'(error), 0);
    @(negedge clk);
    alloc_req = 1'b0;
    #1;
    check("df_valid", 32'(alloc_valid), 0);
    check("df_count", 32'(free_count), 2);
    @(negedge clk);
    force_deq_fail = 1'b0;
    #1;
    check("df_err1", 32'(error), 1);
    repeat (3) @(negedge clk);
    #1;
    check("df_sticky", 32'(error), 1);

    // Reset in the cycle after an accepted allocation
    @(negedge clk);
    alloc_req = 1'b1;
    #1;
    check("mr_deq", 32'(fl_deq), 1);
    @(negedge clk);
    alloc_req = 1'b0; reset = 1'b1;
    #1;
    check("mr_valid_rst", 32'(alloc_valid), 0);
    check("mr_enq_rst", 32'(fl_enq), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mr_valid", 32'(alloc_valid), 0);
    check("mr_count", 32'(free_count), 0);
    check("mr_error", 32'(error), 0);
    check("mr_busy", 32'(busy), 1);
    check("mr_walk32", 32'(fl_enq_data), 32);
    @(negedge clk); #1;
    check("mr_walk33", 32'(fl_enq_data), 33);
    repeat (31) @(negedge clk);
    #1;
    check("mr_run", 32'(busy), 0);
    check("mr_count32", 32'(free_count), 32);

    // Overflow: fill to 64 with commit frees, one more is suppressed and flagged
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      commit_free = 1'b1; commit_preg = 6'(j);
    end
    @(negedge clk);
    commit_preg = 6'd7;
    #1;
    check("ov_count", 32'(free_count), 64);
    check("ov_noenq", 32'(fl_enq), 0);
    check("ov_err0", 32'(error), 0);
    @(negedge clk);
    commit_free = 1'b0;
    #1;
    check("ov_err1", 32'(error), 1);
    check("ov_count2", 32'(free_count), 64);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
